// File: rtl/wb_port_sched_if.sv
// Writeback scheduler bus: command handshake, register-file write port,
// decode hazard probe and retirement status.
interface wb_port_sched_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic        hz_a;
  logic        hz_b;
  logic        wb_done;
  logic [15:0] wr_count;

  modport master (
    output in_valid, icode, rA, rB, cnd, valE, valM, rd_addr_a, rd_addr_b,
    input  in_ready, wr_en, wr_addr, wr_data, hz_a, hz_b, wb_done, wr_count
  );

  modport slave (
    input  in_valid, icode, rA, rB, cnd, valE, valM, rd_addr_a, rd_addr_b,
    output in_ready, wr_en, wr_addr, wr_data, hz_a, hz_b, wb_done, wr_count
  );
endinterface

// File: rtl/wb_port_sched.sv
// Serialises the up-to-two register writes of a Y86 writeback command onto a
// single register-file write port, with hazard flags for decode reads.
module wb_port_sched #(
  parameter logic [3:0] RNONE = 4'hF,
  parameter logic [3:0] RSP   = 4'd4
) (
  input  logic clk,
  input  logic rst_n,
  wb_port_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, W1, W2} state_t;

  state_t      r_state;
  logic        r_wr_en;
  logic [3:0]  r_wr_addr;
  logic [63:0] r_wr_data;
  logic        r_wb_done;
  logic        r_has2;
  logic [3:0]  r_pend_addr;
  logic [63:0] r_pend_data;
  logic [15:0] r_count;

  logic        w_v0, w_v1, w_ok0, w_ok1;
  logic [3:0]  w_a0, w_a1;
  logic [63:0] w_d0, w_d1;
  logic        w_has_first, w_has_second;
  logic [3:0]  w_first_addr;
  logic [63:0] w_first_data;
  logic        w_final, w_ready, w_accept;
  logic        w_hz_a, w_hz_b;

  // Raw write slots in architectural order; slot 0 precedes slot 1.
  always_comb begin
    w_v0 = 1'b0;
    w_a0 = 4'd0;
    w_d0 = 64'd0;
    w_v1 = 1'b0;
    w_a1 = 4'd0;
    w_d1 = 64'd0;
    case (bus.icode)
      4'h2: begin w_v0 = bus.cnd; w_a0 = bus.rB; w_d0 = bus.valE; end
      4'h3, 4'h6: begin w_v0 = 1'b1; w_a0 = bus.rB; w_d0 = bus.valE; end
      4'h5: begin w_v0 = 1'b1; w_a0 = bus.rA; w_d0 = bus.valM; end
      4'h8, 4'h9, 4'hA: begin w_v0 = 1'b1; w_a0 = RSP; w_d0 = bus.valE; end
      4'hB: begin
        w_v0 = 1'b1; w_a0 = RSP;    w_d0 = bus.valE;
        w_v1 = 1'b1; w_a1 = bus.rA; w_d1 = bus.valM;
      end
      default: ;
    endcase
  end

  // A suppressed slot 0 lets slot 1 move up to be the only write.
  assign w_ok0        = w_v0 && (w_a0 != RNONE);
  assign w_ok1        = w_v1 && (w_a1 != RNONE);
  assign w_has_first  = w_ok0 || w_ok1;
  assign w_has_second = w_ok0 && w_ok1;
  assign w_first_addr = w_ok0 ? w_a0 : w_a1;
  assign w_first_data = w_ok0 ? w_d0 : w_d1;

  assign w_final  = r_wr_en && !r_has2;
  assign w_ready  = rst_n && ((r_state == IDLE) || w_final);
  assign w_accept = bus.in_valid && w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= 4'd0;
      r_wr_data   <= 64'd0;
      r_wb_done   <= 1'b0;
      r_has2      <= 1'b0;
      r_pend_addr <= 4'd0;
      r_pend_data <= 64'd0;
      r_count     <= 16'd0;
    end else begin
      if (r_wr_en) begin
        r_count <= r_count + 16'd1;
      end
      if (w_accept) begin
        // Commands with at most one write retire in the next cycle.
        r_wb_done   <= !w_has_second;
        r_has2      <= w_has_second;
        r_pend_addr <= w_a1;
        r_pend_data <= w_d1;
        if (w_has_first) begin
          r_state   <= W1;
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_first_addr;
          r_wr_data <= w_first_data;
        end else begin
          r_state   <= IDLE;
          r_wr_en   <= 1'b0;
          r_wr_addr <= 4'd0;
          r_wr_data <= 64'd0;
        end
      end else if (r_state == W1 && r_has2) begin
        r_state   <= W2;
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_pend_addr;
        r_wr_data <= r_pend_data;
        r_wb_done <= 1'b1;
        r_has2    <= 1'b0;
      end else begin
        r_state   <= IDLE;
        r_wr_en   <= 1'b0;
        r_wr_addr <= 4'd0;
        r_wr_data <= 64'd0;
        r_wb_done <= 1'b0;
        r_has2    <= 1'b0;
      end
    end
  end

  // Pending = the write on the port now plus any queued second write.
  assign w_hz_a = (bus.rd_addr_a != RNONE) &&
                  ((r_wr_en && bus.rd_addr_a == r_wr_addr) ||
                   (r_has2  && bus.rd_addr_a == r_pend_addr));
  assign w_hz_b = (bus.rd_addr_b != RNONE) &&
                  ((r_wr_en && bus.rd_addr_b == r_wr_addr) ||
                   (r_has2  && bus.rd_addr_b == r_pend_addr));

  assign bus.in_ready = w_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.wb_done  = r_wb_done;
  assign bus.hz_a     = w_hz_a;
  assign bus.hz_b     = w_hz_b;
  assign bus.wr_count = r_count;

endmodule

// File: doc/wb_port_sched.md
WB_PORT_SCHED -- requirements
Module: wb_port_sched

Interface
REQ-001 SHALL have parameter RNONE, default 4'hF, meaning register index that denotes "no register" and never produces a write.
REQ-002 SHALL have parameter RSP, default 4'd4, meaning stack-pointer register index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  writeback command present.
REQ-006 SHALL have port in_ready  output  1  scheduler accepts command this cycle.
REQ-007 SHALL have ports icode, rA, rB  input  4 each  instruction code and register specifiers of the command.
REQ-008 SHALL have port cnd  input  1  condition result (cmovXX only).
REQ-009 SHALL have ports valE, valM  input  64 each  ALU result and memory read data.
REQ-010 SHALL have ports wr_en  output  1, wr_addr  output  4, wr_data  output  64  single write port to the register file.
REQ-011 SHALL have ports rd_addr_a, rd_addr_b  input  4 each  decode read addresses to be hazard-checked.
REQ-012 SHALL have ports hz_a, hz_b  output  1 each  read address matches a pending write.
REQ-013 SHALL have port wb_done  output  1  one-cycle pulse when a command fully retires.
REQ-014 SHALL have port wr_count  output  16  total register writes issued.

Function
REQ-015 SHALL accept a command on a rising edge where in_valid and in_ready are both 1, latching icode, rA, rB, cnd, valE, valM.
REQ-016 SHALL derive writes from the latched command: cmovXX (2) rB<-valE only if cnd=1; irmovq (3) rB<-valE; mrmovq (5) rA<-valM; OPq (6) rB<-valE; call (8), ret (9), pushq (A) RSP<-valE; popq (B) RSP<-valE then rA<-valM; all other icodes no write.
REQ-017 SHALL suppress any write whose target address equals RNONE.
REQ-018 SHALL implement states IDLE, W1, W2; IDLE->W1 on accept with >=1 write; W1->W2 if a second write remains; W1/W2->IDLE after final write unless a new command is accepted in that cycle (then ->W1, or IDLE with zero writes).
REQ-019 SHALL drive wr_en=1 with the first write in W1 and the second write in W2, one write per cycle, first write in the cycle after acceptance.
REQ-020 SHALL issue popq writes in order RSP then rA, so popq with rA=RSP leaves valM in RSP.
REQ-021 SHALL drive in_ready=1 in IDLE and in the cycle of the final write of the current command; 0 otherwise.
REQ-022 SHALL, for a command with zero writes, remain in IDLE, keep wr_en=0, and pulse wb_done in the cycle after acceptance.
REQ-023 SHALL pulse wb_done in the cycle of the final write of a command with >=1 write.
REQ-024 SHALL assert hz_a (hz_b) combinationally when rd_addr_a (rd_addr_b) equals the address of any latched write not yet completed before the current cycle, including the write on wr_addr this cycle; RNONE never matches.
REQ-025 SHALL increment wr_count by 1 on every edge where wr_en=1, wrapping from 16'hFFFF to 0.
REQ-026 SHALL drive wr_addr=0 and wr_data=0 whenever wr_en=0.

Reset
REQ-027 SHALL, while rst_n=0, immediately force state IDLE, wr_en=0, wr_addr=0, wr_data=0, wb_done=0, hz_a=hz_b=0, wr_count=0, in_ready=0, and discard any pending writes.
REQ-028 SHALL resume with in_ready=1 on the first cycle after rst_n rises.

Verification
REQ-029 SHALL pass: irmovq rB=3, valE=64'h55 accepted at edge N -> wr_en=1, wr_addr=3, wr_data=64'h55, wb_done=1 in cycle N+1; wr_count=1.
REQ-030 SHALL pass: popq rA=4, valE=64'h108, valM=64'hAB -> cycle N+1 write (4,64'h108), cycle N+2 write (4,64'hAB), wb_done only in N+2, in_ready=0 in N+1.
REQ-031 SHALL pass: cmovXX cnd=0 rB=2, then cmovXX cnd=1 rB=2 valE=7 -> first: no write, wb_done next cycle; second: single write (2,7).
REQ-032 SHALL pass: popq rA=1 in flight, rd_addr_a=1, rd_addr_b=4 -> N+1 hz_a=1, hz_b=1; N+2 hz_a=1, hz_b=0; N+3 both 0.
REQ-033 SHALL pass: back-to-back OPq rB=5 and pushq accepted on consecutive ready edges -> writes (5,valE1) then (4,valE2) in adjacent cycles, no idle gap.
REQ-034 SHALL pass: rst_n pulled low during W1 of popq -> wr_en=0 immediately, no W2 write after release, wr_count=0.
